// File: rtl/lcd_timing_gen.sv
// ---------------------------------------------------------------------------
// lcd_timing_gen : raster HSYNC/VSYNC/DE timing, pixel-coordinate request
//                  and DE-aligned RGB register for a parallel RGB LCD panel
// Revision 1.0   : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module lcd_timing_gen #(
  parameter int H_SYNC  = 41,
  parameter int H_BACK  = 2,
  parameter int H_DISP  = 480,
  parameter int H_FRONT = 2,
  parameter int V_SYNC  = 10,
  parameter int V_BACK  = 2,
  parameter int V_DISP  = 272,
  parameter int V_FRONT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lcd_en,
  input  logic [23:0] lcd_data,
  output logic [11:0] lcd_xpos,
  output logic [11:0] lcd_ypos,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [23:0] lcd_rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [11:0] C_H_SYNC = 12'(H_SYNC);
  localparam logic [11:0] C_V_SYNC = 12'(V_SYNC);
  localparam logic [11:0] C_H_ACT0 = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] C_H_ACT1 = 12'(H_SYNC + H_BACK + H_DISP);
  localparam logic [11:0] C_V_ACT0 = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] C_V_ACT1 = 12'(V_SYNC + V_BACK + V_DISP);
  localparam logic [11:0] C_H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] C_V_LAST = 12'(V_TOTAL - 1);

  function automatic logic in_active(input logic [11:0] h, input logic [11:0] v);
    return (h >= C_H_ACT0) && (h < C_H_ACT1) && (v >= C_V_ACT0) && (v < C_V_ACT1);
  endfunction

  logic [11:0] h_q, v_q, h_d, v_d;
  logic [11:0] xpos_q, ypos_q, xpos_d, ypos_d;
  logic        hs1_q, vs1_q, de1_q, fs1_q;
  logic        hs1_d, vs1_d, de1_d, fs1_d;
  logic        hs_q, vs_q, de_q, fs_q;
  logic [23:0] rgb_q;

  // Request timeline: next raster position, parked at (0,0) while disabled.
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (lcd_en) begin
      if (h_q == C_H_LAST) begin
        h_d = '0;
        v_d = (v_q == C_V_LAST) ? 12'd0 : v_q + 12'd1;
      end else begin
        h_d = h_q + 12'd1;
        v_d = v_q;
      end
    end
  end

  // First pipeline stage: decode of the current request position.
  always_comb begin
    hs1_d = 1'b1;
    vs1_d = 1'b1;
    de1_d = 1'b0;
    fs1_d = 1'b0;
    if (lcd_en) begin
      hs1_d = (h_q >= C_H_SYNC);
      vs1_d = (v_q >= C_V_SYNC);
      de1_d = in_active(h_q, v_q);
      fs1_d = (h_q == 12'd0) && (v_q == 12'd0);
    end
  end

  // Coordinates are registered one cycle ahead so they line up with h_q/v_q.
  always_comb begin
    xpos_d = '0;
    ypos_d = '0;
    if (lcd_en && in_active(h_d, v_d)) begin
      xpos_d = h_d - C_H_ACT0;
      ypos_d = v_d - C_V_ACT0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q    <= '0;
      v_q    <= '0;
      xpos_q <= '0;
      ypos_q <= '0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      de1_q  <= 1'b0;
      fs1_q  <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      de_q   <= 1'b0;
      fs_q   <= 1'b0;
      rgb_q  <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      xpos_q <= xpos_d;
      ypos_q <= ypos_d;
      hs1_q  <= hs1_d;
      vs1_q  <= vs1_d;
      de1_q  <= de1_d;
      fs1_q  <= fs1_d;
      hs_q   <= hs1_q;
      vs_q   <= vs1_q;
      de_q   <= de1_q;
      fs_q   <= fs1_q;
      rgb_q  <= de1_q ? lcd_data : 24'd0;
    end
  end

  assign lcd_xpos    = xpos_q;
  assign lcd_ypos    = ypos_q;
  assign lcd_hs      = hs_q;
  assign lcd_vs      = vs_q;
  assign lcd_de      = de_q;
  assign lcd_rgb     = rgb_q;
  assign frame_start = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_lcd_timing_gen : scoreboard bench for lcd_timing_gen with an echo
//                     data generator and a linear-raster-index reference model
// Revision 1.0      : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lcd_timing_gen;

  localparam int HS = 3, HB = 2, HD = 8, HF = 2;
  localparam int VS = 2, VB = 1, VD = 4, VF = 1;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [23:0] rgb;
    logic [11:0] x;
    logic [11:0] y;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        lcd_en = 1'b0;
  logic [23:0] gen_q;
  logic [11:0] lcd_xpos, lcd_ypos;
  logic        lcd_hs, lcd_vs, lcd_de, frame_start;
  logic [23:0] lcd_rgb;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  lcd_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lcd_en     (lcd_en),
    .lcd_data   (gen_q),
    .lcd_xpos   (lcd_xpos),
    .lcd_ypos   (lcd_ypos),
    .lcd_hs     (lcd_hs),
    .lcd_vs     (lcd_vs),
    .lcd_de     (lcd_de),
    .lcd_rgb    (lcd_rgb),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Echo generator: returns the requested coordinate one cycle later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) gen_q <= '0;
    else        gen_q <= {lcd_ypos, lcd_xpos};
  end

  function automatic exp_t idle_val();
    exp_t r;
    r = '0;
    r.hs = 1'b1;
    r.vs = 1'b1;
    return r;
  endfunction

  // What the panel should see for linear raster index n (0 = frame origin).
  function automatic exp_t pix(input int n);
    exp_t r;
    int   h, v;
    h    = n % HT;
    v    = n / HT;
    r    = '0;
    r.hs = (h >= HS);
    r.vs = (v >= VS);
    r.de = (h >= HS + HB) && (h < HS + HB + HD) && (v >= VS + VB) && (v < VS + VB + VD);
    r.fs = (n == 0);
    if (r.de) r.rgb = {12'(v - VS - VB), 12'(h - HS - HB)};
    return r;
  endfunction

  // Reference model: n is the raster index being requested; a requested
  // pixel reaches the panel two clocks after its index is current.
  int   m_n = 0;
  exp_t m_pend;
  initial m_pend = idle_val();

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    exp_t nxt;
    if (!rst_n) begin
      m_n    = 0;
      m_pend = idle_val();
      q.push_back(idle_val());
    end else begin
      e      = m_pend;
      m_pend = lcd_en ? pix(m_n) : idle_val();
      m_n    = lcd_en ? (m_n + 1) % FT : 0;
      if (lcd_en) begin
        nxt = pix(m_n);
        e.x = nxt.rgb[11:0];
        e.y = nxt.rgb[23:12];
      end
      q.push_back(e);
    end
  end

  // Monitor: checks every queued expectation against the live outputs.
  always begin
    exp_t e;
    exp_t a;
    @(negedge clk or negedge rst_n);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      a = '{hs: lcd_hs, vs: lcd_vs, de: lcd_de, fs: frame_start,
            rgb: lcd_rgb, x: lcd_xpos, y: lcd_ypos};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs @%0t: got hs=%b vs=%b de=%b fs=%b rgb=%h x=%0d y=%0d, want hs=%b vs=%b de=%b fs=%b rgb=%h x=%0d y=%0d",
                 $time, a.hs, a.vs, a.de, a.fs, a.rgb, a.x, a.y,
                 e.hs, e.vs, e.de, e.fs, e.rgb, e.x, e.y);
      end
    end
  end

  task automatic check_idle(input string tag);
    exp_t a;
    a = '{hs: lcd_hs, vs: lcd_vs, de: lcd_de, fs: frame_start,
          rgb: lcd_rgb, x: lcd_xpos, y: lcd_ypos};
    if (a !== idle_val()) begin
      miscompares++;
      $display("FAIL %s @%0t: outputs not idle: hs=%b vs=%b de=%b fs=%b rgb=%h x=%0d y=%0d",
               tag, $time, a.hs, a.vs, a.de, a.fs, a.rgb, a.x, a.y);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset(input int hold);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle("reset");
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit seen;
    #1 rst_n = 1'b0;
    lcd_en = 1'b1;
    run(3);
    check_idle("initial reset");
    rst_n = 1'b1;
    run(2 * FT + 7);

    pulse_reset(2);
    run(FT + 3);

    @(negedge clk);
    lcd_en = 1'b0;
    run(3);
    check_idle("lcd_en low");
    run(997);
    lcd_en = 1'b1;
    seen = 1'b0;
    fork
      begin
        wait (frame_start === 1'b1);
        seen = 1'b1;
      end
      begin
        repeat (6) @(posedge clk);
      end
    join_any
    disable fork;
    if (!seen) begin
      miscompares++;
      $display("FAIL timeout @%0t: frame_start not seen after lcd_en rise", $time);
    end
    run(FT + 11);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          lcd_en = 1'b0;
          run($urandom_range(1, 40));
          lcd_en = 1'b1;
        end
        1: pulse_reset($urandom_range(1, 3));
        default: run($urandom_range(10, 2 * FT));
      endcase
    end
    run(FT);

    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares == 0 && vectors > 0) $display("PASS");
    else                                 $display("FAIL");
    $finish;
  end

endmodule

`default_nettype wire
